sa_block_sequencer: RTL and testbench

Sequences the systolic-array stream wrapper. Frames the raw DMA input stream into blocks of `cfg_k` beats by writing the SOB and EOB flag bits. Also throttles block issue with a credit counter, because the wrapper's result FIFO has no write backpressure: issued-but-undrained results never exceed `FIFO_DEPTH` words. Sits between the DMA read stream and the wrapper's slave port, and snoops the wrapper's master handshake to retire blocks.

---
 rtl/sa_seq_pkg.sv | 19 +
 rtl/sa_credit_counter.sv | 43 ++++
 rtl/sa_block_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_sa_block_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_seq_pkg.sv
// Shared types and constants for the systolic-array block sequencer.
// Flag offsets count down from the stream MSB.
package sa_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int EOB_OFS = 1;
    localparam int SOB_OFS = 2;

    function automatic int credit_w(int max_blocks);
        return $clog2(max_blocks + 1);
    endfunction

endpackage

// File: rtl/sa_credit_counter.sv
// Credit pool guarding the wrapper result FIFO.
// One credit per issued block, returned when its last result word drains.
module sa_credit_counter
    import sa_seq_pkg::*;
#(
    parameter int MAX_BLOCKS = 32,
    localparam int CW = credit_w(MAX_BLOCKS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init,
    input  logic          consume,
    input  logic          ret,
    output logic [CW-1:0] credits,
    output logic          empty
);

    localparam logic [CW-1:0] FULL = CW'(MAX_BLOCKS);

    logic [CW-1:0] r_credits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= FULL;
        end else if (init) begin
            r_credits <= FULL;
        end else if (consume && !ret && r_credits != '0) begin
            r_credits <= r_credits - CW'(1);
        end else if (ret && !consume && r_credits != FULL) begin
            r_credits <= r_credits + CW'(1);
        end
    end

    assign credits = r_credits;
    assign empty   = (r_credits == '0);

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        (consume && !ret && !init) |-> !empty);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (ret && !consume && !init) |-> (r_credits != FULL));

endmodule

// File: rtl/sa_block_sequencer.sv
// Frames the DMA stream into SOB/EOB-flagged blocks of cfg_k beats and
// throttles block issue so undrained results never exceed the result FIFO.
module sa_block_sequencer
    import sa_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 1024,
    parameter int N          = 32,
    parameter int FIFO_DEPTH = 1024,
    parameter int K_WIDTH    = 16,
    parameter int CNT_WIDTH  = 32,
    localparam int MAX_BLOCKS = FIFO_DEPTH / N,
    localparam int CRW        = credit_w(MAX_BLOCKS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [K_WIDTH-1:0]    cfg_k_i,
    input  logic [CNT_WIDTH-1:0]  cfg_nblocks_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cfg_err_o,
    output logic [CRW-1:0]        credits_o,
    output logic [CNT_WIDTH-1:0]  blocks_issued_o,
    input  logic                  s_rts_i,
    output logic                  s_rtr_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  m_rts_o,
    input  logic                  m_rtr_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  res_rts_i,
    input  logic                  res_rtr_i
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [RW-1:0] RES_LAST = RW'(N - 1);

    state_t                 r_state;
    logic [K_WIDTH-1:0]     r_k;
    logic [K_WIDTH-1:0]     r_beat;
    logic [CNT_WIDTH-1:0]   r_nblocks;
    logic [CNT_WIDTH-1:0]   r_issued;
    logic [CNT_WIDTH-1:0]   r_retired;
    logic [RW-1:0]          r_res;
    logic                   r_done;
    logic                   r_err;

    logic                   w_stream;
    logic                   w_mid;
    logic                   w_empty;
    logic                   w_gate;
    logic                   w_sob;
    logic                   w_eob;
    logic                   w_fire;
    logic                   w_sob_fire;
    logic                   w_res_hs;
    logic                   w_ret;
    logic                   w_start_ok;
    logic [CNT_WIDTH-1:0]   w_retired_nx;
    logic [DATA_WIDTH-1:0]  w_data;

    assign w_stream   = (r_state == ST_STREAM);
    assign w_mid      = (r_beat != '0);
    // A block in flight always finishes; only a fresh SOB needs a credit.
    assign w_gate     = w_stream
                      & (w_mid | !w_empty)
                      & (w_mid | (r_issued < r_nblocks));
    assign s_rtr_o    = m_rtr_i & w_gate;
    assign m_rts_o    = s_rts_i & w_gate;
    assign w_sob      = w_stream & !w_mid;
    assign w_eob      = w_stream & (r_beat == r_k - K_WIDTH'(1));
    assign w_fire     = s_rts_i & s_rtr_o;
    assign w_sob_fire = w_fire & !w_mid;
    assign w_res_hs   = res_rts_i & res_rtr_i
                      & ((r_state == ST_STREAM) | (r_state == ST_DRAIN));
    assign w_ret      = w_res_hs & (r_res == RES_LAST);
    assign w_start_ok = (r_state == ST_IDLE) & start_i & (cfg_k_i != '0);
    assign w_retired_nx = r_retired + CNT_WIDTH'(w_ret);

    always_comb begin
        w_data = s_data_i;
        w_data[DATA_WIDTH-EOB_OFS] = w_eob;
        w_data[DATA_WIDTH-SOB_OFS] = w_sob;
    end

    assign m_data_o        = w_data;
    assign busy_o          = (r_state != ST_IDLE);
    assign done_o          = r_done;
    assign cfg_err_o       = r_err;
    assign blocks_issued_o = r_issued;

    sa_credit_counter #(
        .MAX_BLOCKS(MAX_BLOCKS)
    ) u_credits (
        .clk     (clk),
        .rst_n   (rst_n),
        .init    (w_start_ok),
        .consume (w_sob_fire),
        .ret     (w_ret),
        .credits (credits_o),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k       <= '0;
            r_nblocks <= '0;
            r_beat    <= '0;
            r_issued  <= '0;
            r_retired <= '0;
            r_res     <= '0;
        end else if (w_start_ok) begin
            r_k       <= cfg_k_i;
            r_nblocks <= cfg_nblocks_i;
            r_beat    <= '0;
            r_issued  <= '0;
            r_retired <= '0;
            r_res     <= '0;
        end else begin
            if (w_fire) begin
                r_beat <= w_eob ? '0 : r_beat + K_WIDTH'(1);
            end
            if (w_sob_fire) begin
                r_issued <= r_issued + CNT_WIDTH'(1);
            end
            if (w_res_hs) begin
                r_res <= (r_res == RES_LAST) ? '0 : r_res + RW'(1);
            end
            if (w_ret) begin
                r_retired <= w_retired_nx;
            end
        end
    end

    // DONE is entered with r_done set after a drain, clear for an empty job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (cfg_k_i == '0) begin
                            r_err <= 1'b1;
                        end else if (cfg_nblocks_i == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (r_issued == r_nblocks && !w_mid) begin
                        if (w_retired_nx == r_nblocks) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_retired_nx == r_nblocks) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done <= !r_done;
                    if (r_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_block_sequencer.sv
// Directed bench for sa_block_sequencer with a two-credit pool
// (FIFO_DEPTH=64, N=32) and a narrow 16-bit stream.
module tb_sa_block_sequencer;

    localparam int DW  = 16;
    localparam int NW  = 32;
    localparam int FD  = 64;
    localparam int KW  = 16;
    localparam int CW  = 32;
    localparam int CRW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_i = 1'b0;
    logic [KW-1:0]  cfg_k_i = '0;
    logic [CW-1:0]  cfg_nblocks_i = '0;
    logic           busy_o;
    logic           done_o;
    logic           cfg_err_o;
    logic [CRW-1:0] credits_o;
    logic [CW-1:0]  blocks_issued_o;
    logic           s_rts_i = 1'b0;
    logic           s_rtr_o;
    logic [DW-1:0]  s_data_i = '0;
    logic           m_rts_o;
    logic           m_rtr_i = 1'b0;
    logic [DW-1:0]  m_data_o;
    logic           res_rts_i = 1'b0;
    logic           res_rtr_i = 1'b0;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sa_block_sequencer #(
        .DATA_WIDTH(DW),
        .N(NW),
        .FIFO_DEPTH(FD),
        .K_WIDTH(KW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start_i),
        .cfg_k_i(cfg_k_i),
        .cfg_nblocks_i(cfg_nblocks_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .cfg_err_o(cfg_err_o),
        .credits_o(credits_o),
        .blocks_issued_o(blocks_issued_o),
        .s_rts_i(s_rts_i),
        .s_rtr_o(s_rtr_o),
        .s_data_i(s_data_i),
        .m_rts_o(m_rts_o),
        .m_rtr_i(m_rtr_i),
        .m_data_o(m_data_o),
        .res_rts_i(res_rts_i),
        .res_rtr_i(res_rtr_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Always-ready job; results are returned only for blocks already issued.
    task automatic run_job(input int k, input int nb, input int bust);
        int  beats = 0;
        int  sobs = 0;
        int  res_sent = 0;
        bit  seen = 1'b0;
        bit  fin = 1'b0;
        cfg_k_i = KW'(k);
        cfg_nblocks_i = CW'(nb);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 0; c < 600 && !fin; c++) begin
            s_rts_i = 1'b1;
            m_rtr_i = 1'b1;
            s_data_i = DW'($urandom);
            res_rts_i = (res_sent < NW * sobs);
            res_rtr_i = res_rts_i;
            start_i = (c == bust);
            cfg_k_i = (c == bust) ? KW'(1) : KW'(k);
            cfg_nblocks_i = (c == bust) ? CW'(7) : CW'(nb);
            mid();
            if (m_rts_o && m_rtr_i) begin
                chk("sob_flag", m_data_o[DW-2], (beats % k) == 0);
                chk("eob_flag", m_data_o[DW-1], (beats % k) == k - 1);
                chk("data_pass", m_data_o[DW-3:0], s_data_i[DW-3:0]);
                if (beats % k == 0) sobs++;
                beats++;
            end
            if (res_rts_i) res_sent++;
            if (seen) begin
                chk("busy_after_done", busy_o, 1'b0);
                chk("done_one_cycle", done_o, 1'b0);
                fin = 1'b1;
            end else if (done_o) begin
                seen = 1'b1;
                chk("busy_at_done", busy_o, 1'b1);
                chk("results_at_done", res_sent, NW * nb);
            end
            step();
        end
        chk("done_seen", seen, 1'b1);
        chk("beats_forwarded", beats, k * nb);
        chk("blocks_issued", blocks_issued_o, nb);
        start_i = 1'b0;
        s_rts_i = 1'b0;
        res_rts_i = 1'b0;
        res_rtr_i = 1'b0;
    endtask

    initial begin
        int fires;
        int sobs;

        // Reset values
        s_rts_i = 1'b1;
        m_rtr_i = 1'b1;
        s_data_i = 16'hFABC;
        mid();
        chk("rst_s_rtr", s_rtr_o, 1'b0);
        chk("rst_m_rts", m_rts_o, 1'b0);
        chk("rst_m_data", m_data_o, 16'h3ABC);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", cfg_err_o, 1'b0);
        chk("rst_credits", credits_o, 2);
        chk("rst_issued", blocks_issued_o, 0);
        rst_n = 1'b1;
        s_rts_i = 1'b0;
        step();

        // cfg_k == 0 is rejected
        cfg_k_i = '0;
        cfg_nblocks_i = 3;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        mid();
        chk("kzero_err", cfg_err_o, 1'b1);
        chk("kzero_busy", busy_o, 1'b0);
        step();
        mid();
        chk("kzero_err_pulse", cfg_err_o, 1'b0);
        chk("kzero_idle", busy_o, 1'b0);

        // Empty job: done two cycles after start, nothing forwarded
        step();
        cfg_k_i = 2;
        cfg_nblocks_i = 0;
        s_rts_i = 1'b1;
        m_rtr_i = 1'b1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        mid();
        chk("nb0_busy1", busy_o, 1'b1);
        chk("nb0_done1", done_o, 1'b0);
        chk("nb0_mrts1", m_rts_o, 1'b0);
        step();
        mid();
        chk("nb0_done2", done_o, 1'b1);
        chk("nb0_mrts2", m_rts_o, 1'b0);
        step();
        mid();
        chk("nb0_done3", done_o, 1'b0);
        chk("nb0_busy3", busy_o, 1'b0);
        chk("nb0_issued", blocks_issued_o, 0);
        s_rts_i = 1'b0;
        step();

        // k=4 x 3 blocks with an ignored start mid-job, then k=1 x 2
        run_job(4, 3, 3);
        step();
        run_job(1, 2, -1);
        step();

        // Credit exhaustion: results held off
        cfg_k_i = 2;
        cfg_nblocks_i = 4;
        s_rts_i = 1'b1;
        m_rtr_i = 1'b1;
        res_rts_i = 1'b1;
        res_rtr_i = 1'b0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        fires = 0;
        sobs = 0;
        repeat (10) begin
            mid();
            if (m_rts_o && m_rtr_i) begin
                fires++;
                if (m_data_o[DW-2]) sobs++;
            end
            step();
        end
        mid();
        chk("exh_fires", fires, 4);
        chk("exh_sobs", sobs, 2);
        chk("exh_s_rtr", s_rtr_o, 1'b0);
        chk("exh_m_rts", m_rts_o, 1'b0);
        chk("exh_credits", credits_o, 0);
        chk("exh_issued", blocks_issued_o, 2);

        // 32 results free exactly one more block
        res_rtr_i = 1'b1;
        fires = 0;
        sobs = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 31) res_rtr_i = 1'b0;
            mid();
            if (m_rts_o && m_rtr_i) begin
                fires++;
                if (m_data_o[DW-2]) sobs++;
            end
        end
        chk("rel_fires", fires, 2);
        chk("rel_sobs", sobs, 1);
        chk("rel_s_rtr", s_rtr_o, 1'b0);
        chk("rel_credits", credits_o, 0);
        chk("rel_issued", blocks_issued_o, 3);

        // Same-cycle SOB consume and credit return
        s_rts_i = 1'b0;
        res_rtr_i = 1'b1;
        repeat (32) step();
        chk("ret_credits", credits_o, 1);
        repeat (31) step();
        s_rts_i = 1'b1;
        #1;
        chk("sim_s_rtr", s_rtr_o, 1'b1);
        chk("sim_sob", m_data_o[DW-2], 1'b1);
        chk("sim_credits_before", credits_o, 1);
        step();
        s_rts_i = 1'b0;
        res_rtr_i = 1'b0;
        mid();
        chk("sim_credits_after", credits_o, 1);
        chk("sim_issued", blocks_issued_o, 4);

        // Finish last block and drain
        s_rts_i = 1'b1;
        #1;
        chk("last_eob", m_data_o[DW-1], 1'b1);
        chk("last_m_rts", m_rts_o, 1'b1);
        step();
        s_rts_i = 1'b0;
        res_rtr_i = 1'b1;
        repeat (32) step();
        res_rtr_i = 1'b0;
        mid();
        chk("exh_done", done_o, 1'b1);
        chk("exh_done_busy", busy_o, 1'b1);
        step();
        mid();
        chk("exh_done_pulse", done_o, 1'b0);
        chk("exh_idle", busy_o, 1'b0);
        chk("exh_credits_full", credits_o, 2);
        res_rts_i = 1'b0;

        // Async reset on beat 2 of 4
        step();
        cfg_k_i = 4;
        cfg_nblocks_i = 2;
        s_rts_i = 1'b1;
        m_rtr_i = 1'b1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
        mid();
        chk("mid_sob_clear", m_data_o[DW-2], 1'b0);
        chk("mid_issued", blocks_issued_o, 1);
        chk("mid_credits", credits_o, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_m_rts", m_rts_o, 1'b0);
        chk("arst_s_rtr", s_rtr_o, 1'b0);
        chk("arst_flags", m_data_o[DW-1:DW-2], 2'b00);
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_credits", credits_o, 2);
        chk("arst_issued", blocks_issued_o, 0);
        mid();
        rst_n = 1'b1;
        step();
        cfg_nblocks_i = 1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        mid();
        chk("new_m_rts", m_rts_o, 1'b1);
        chk("new_sob", m_data_o[DW-2], 1'b1);
        chk("new_eob", m_data_o[DW-1], 1'b0);
        s_rts_i = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
